// File: rtl/adma_desc_fetch_pkg.sv
// Shared types and constants for the ADMA descriptor fetch stage: FSM encoding,
// descriptor layout and function codes.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RETRY = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  localparam int DESC_BEATS  = 4;
  localparam int DC_CONT_BIT = 14;

  localparam int DC_NULL = 1;
  localparam int DC_READ = 2;
  localparam int DC_FILL = 13;
  localparam int DC_COPY = 22;

  // Byte offsets of the 32-bit words inside a 32-byte descriptor.
  localparam int OFS_CTL  = 0;
  localparam int OFS_NEXT = 4;
  localparam int OFS_U0   = 8;
  localparam int OFS_DCFC = 12;
  localparam int OFS_U1   = 16;
  localparam int OFS_SRC  = 20;
  localparam int OFS_U2   = 24;
  localparam int OFS_DST  = 28;

  localparam logic [1:0] BEAT_NEXT_CTL = 2'd0;
  localparam logic [1:0] BEAT_DCFC     = 2'd1;
  localparam logic [1:0] BEAT_SRC      = 2'd2;
  localparam logic [1:0] BEAT_DST      = 2'd3;

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] beat);
    return base + {27'd0, beat, 3'd0};
  endfunction

endpackage

// File: rtl/adma_desc_fetch_if.sv
// Wishbone master bus (64-bit read data split into two 32-bit halves) used by
// the descriptor fetch stage.
interface adma_desc_fetch_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic        wbm_cab_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic [31:0] wbm_dat_i;
  logic [31:0] wbm_dat64_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_adr_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_adr_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
  );
endinterface

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetch: reads one 4-beat descriptor over Wishbone and hands the
// decoded fields to the controller. Optional bus watchdog: ADMA_DESC_TIMEOUT_EN.
module adma_desc_fetch
  import adma_pkg::*;
#(
  parameter int RETRY_MAX = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        fetch_start_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_busy_o,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic        desc_err_o,
  output logic [31:0] desc_next_o,
  output logic [31:0] desc_ctl_o,
  output logic [31:0] desc_dcfc_o,
  output logic        desc_cont_o,
  output logic [31:0] desc_src_o,
  output logic [31:0] desc_dst_o,
  adma_desc_fetch_if.master wbm
);

  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [1:0] LAST_BEAT = 2'(DESC_BEATS - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [1:0]    beat_q, beat_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
  logic [31:0]   next_q, next_d;
  logic [31:0]   ctl_q, ctl_d;
  logic [31:0]   dcfc_q, dcfc_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic          bus_active;
  logic          any_term;

`ifdef ADMA_DESC_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
`endif

  assign bus_active = (state_q == ST_BUS);
  assign any_term   = wbm.wbm_ack_i | wbm.wbm_err_i | wbm.wbm_rty_i;

  // NOTE: every _d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    retry_d = retry_q;
    err_d   = err_q;
    next_d  = next_q;
    ctl_d   = ctl_q;
    dcfc_d  = dcfc_q;
    src_d   = src_q;
    dst_d   = dst_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_start_i) begin
          base_d  = fetch_addr_i;
          beat_d  = 2'd0;
          retry_d = '0;
          // A misaligned pointer is reported without ever touching the bus.
          if (fetch_addr_i[2:0] != 3'd0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (wbm.wbm_err_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wbm.wbm_rty_i) begin
          if (retry_q == RW'(RETRY_MAX)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RETRY;
          end
        end else if (wbm.wbm_ack_i) begin
          retry_d = '0;
          unique case (beat_q)
            BEAT_NEXT_CTL: begin
              next_d = wbm.wbm_dat64_i;
              ctl_d  = wbm.wbm_dat_i;
            end
            BEAT_DCFC: dcfc_d = wbm.wbm_dat64_i;
            BEAT_SRC:  src_d  = wbm.wbm_dat64_i;
            BEAT_DST:  dst_d  = wbm.wbm_dat64_i;
          endcase
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) state_d = ST_DONE;
        end
`ifdef ADMA_DESC_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end

      ST_RETRY: state_d = ST_BUS;

      ST_DONE: begin
        if (desc_ready_i) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

`ifdef ADMA_DESC_TIMEOUT_EN
  always_comb begin
    wd_d = '0;
    if (bus_active && !any_term) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      next_q  <= '0;
      ctl_q   <= '0;
      dcfc_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      next_q  <= next_d;
      ctl_q   <= ctl_d;
      dcfc_q  <= dcfc_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  // Bus controls decode straight from the state register, so an asynchronous
  // reset drops cyc/stb without waiting for a clock.
  assign wbm.wbm_cyc_o = bus_active;
  assign wbm.wbm_stb_o = bus_active;
  assign wbm.wbm_cab_o = bus_active;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = 4'b1111;
  assign wbm.wbm_adr_o = bus_active ? beat_addr(base_q, beat_q) : 32'd0;

  assign fetch_busy_o = (state_q != ST_IDLE);
  assign desc_valid_o = (state_q == ST_DONE);
  assign desc_err_o   = err_q;
  assign desc_next_o  = next_q;
  assign desc_ctl_o   = ctl_q;
  assign desc_dcfc_o  = dcfc_q;
  assign desc_cont_o  = dcfc_q[DC_CONT_BIT];
  assign desc_src_o   = src_q;
  assign desc_dst_o   = dst_q;

endmodule

// File: tb/tb_adma_desc_fetch.sv
// Directed bench for adma_desc_fetch: scripted Wishbone slave, beat address log
// and hand-computed descriptor fields.
module tb_adma_desc_fetch;

  localparam int RETRY_MAX = 4;
  localparam int TIMEOUT   = 16;
  localparam logic [31:0] GAP = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_busy;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic        desc_err;
  logic [31:0] desc_next, desc_ctl, desc_dcfc, desc_src, desc_dst;
  logic        desc_cont;

  adma_desc_fetch_if wbm_if ();

  adma_desc_fetch #(.RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .fetch_start_i (fetch_start),
    .fetch_addr_i  (fetch_addr),
    .fetch_busy_o  (fetch_busy),
    .desc_valid_o  (desc_valid),
    .desc_ready_i  (desc_ready),
    .desc_err_o    (desc_err),
    .desc_next_o   (desc_next),
    .desc_ctl_o    (desc_ctl),
    .desc_dcfc_o   (desc_dcfc),
    .desc_cont_o   (desc_cont),
    .desc_src_o    (desc_src),
    .desc_dst_o    (desc_dst),
    .wbm           (wbm_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Slave memory image and fault script
  logic [31:0] mem_hi [4];
  logic [31:0] mem_lo [4];
  logic [31:0] desc_base = '0;
  int          err_beat  = -1;
  int          rty_beat  = -1;
  int          rty_left  = 0;
  bit          hang      = 1'b0;
  bit          ctl_bad   = 1'b0;
  logic [31:0] adr_log [$];
  logic [31:0] exp_log [$];

  initial begin
    wbm_if.wbm_ack_i   = 1'b0;
    wbm_if.wbm_err_i   = 1'b0;
    wbm_if.wbm_rty_i   = 1'b0;
    wbm_if.wbm_dat_i   = '0;
    wbm_if.wbm_dat64_i = '0;
  end

  // Zero-wait slave: responds in the same cycle the strobe is seen.
  always @(negedge clk) begin
    int b;
    wbm_if.wbm_ack_i = 1'b0;
    wbm_if.wbm_err_i = 1'b0;
    wbm_if.wbm_rty_i = 1'b0;
    if (fetch_busy && !desc_valid)
      adr_log.push_back(wbm_if.wbm_cyc_o ? wbm_if.wbm_adr_o : GAP);
    if (wbm_if.wbm_cyc_o) begin
      if (!wbm_if.wbm_stb_o || !wbm_if.wbm_cab_o || wbm_if.wbm_we_o || wbm_if.wbm_sel_o != 4'hF)
        ctl_bad = 1'b1;
      b = int'((wbm_if.wbm_adr_o - desc_base) >> 3);
      if (hang) begin
      end else if (b == err_beat) begin
        wbm_if.wbm_err_i = 1'b1;
      end else if (b == rty_beat && rty_left > 0) begin
        wbm_if.wbm_rty_i = 1'b1;
        rty_left--;
      end else if (b >= 0 && b < 4) begin
        wbm_if.wbm_ack_i   = 1'b1;
        wbm_if.wbm_dat_i   = mem_lo[b];
        wbm_if.wbm_dat64_i = mem_hi[b];
      end
    end
  end

  task automatic load_desc(input logic [31:0] base, input logic [31:0] nxt, input logic [31:0] ctl,
                           input logic [31:0] dcfc, input logic [31:0] src, input logic [31:0] dst);
    desc_base = base;
    mem_hi[0] = nxt;  mem_lo[0] = ctl;
    mem_hi[1] = dcfc; mem_lo[1] = 32'hDEAD_0001;
    mem_hi[2] = src;  mem_lo[2] = 32'hDEAD_0002;
    mem_hi[3] = dst;  mem_lo[3] = 32'hDEAD_0003;
  endtask

  // Latency counts the start cycle and the first valid cycle inclusively.
  task automatic fetch(input logic [31:0] addr, output int lat);
    @(negedge clk);
    adr_log.delete();
    fetch_start = 1'b1;
    fetch_addr  = addr;
    lat = 1;
    do begin
      @(negedge clk);
      fetch_start = 1'b0;
      lat++;
    end while (!desc_valid && lat < 200);
    if (!desc_valid) check("valid_timeout", 32'(desc_valid), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(adr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < adr_log.size(); i++)
      check($sformatf("%s_adr%0d", tag, i), adr_log[i], exp_log[i]);
  endtask

  task automatic check_desc(input string tag, input logic [31:0] nxt, input logic [31:0] ctl,
                            input logic [31:0] dcfc, input logic cont,
                            input logic [31:0] src, input logic [31:0] dst);
    check({tag, "_valid"}, 32'(desc_valid), 32'd1);
    check({tag, "_err"},   32'(desc_err),   32'd0);
    check({tag, "_next"},  desc_next, nxt);
    check({tag, "_ctl"},   desc_ctl,  ctl);
    check({tag, "_dcfc"},  desc_dcfc, dcfc);
    check({tag, "_cont"},  32'(desc_cont), 32'(cont));
    check({tag, "_src"},   desc_src,  src);
    check({tag, "_dst"},   desc_dst,  dst);
  endtask

  task automatic accept(input string tag);
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(desc_valid), 32'd0);
    check({tag, "_idle_busy"},  32'(fetch_busy), 32'd0);
    check({tag, "_idle_err"},   32'(desc_err),   32'd0);
  endtask

  initial begin
    int lat;
    int waited;

    // Reset state
    #2;
    check("rst_busy",  32'(fetch_busy), 32'd0);
    check("rst_valid", 32'(desc_valid), 32'd0);
    check("rst_err",   32'(desc_err),   32'd0);
    check("rst_cyc",   32'(wbm_if.wbm_cyc_o), 32'd0);
    check("rst_stb",   32'(wbm_if.wbm_stb_o), 32'd0);
    check("rst_cab",   32'(wbm_if.wbm_cab_o), 32'd0);
    check("rst_adr",   wbm_if.wbm_adr_o, 32'd0);
    check("rst_next",  desc_next, 32'd0);
    check("rst_dst",   desc_dst,  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Null descriptor at 0
    load_desc(32'h0, 32'h300, 32'h200, 32'h1, 32'h400, 32'h500);
    fetch(32'h0, lat);
    check("null_latency", 32'(lat), 32'd6);
    exp_log = '{32'h0, 32'h8, 32'h10, 32'h18};
    check_log("null");
    check_desc("null", 32'h300, 32'h200, 32'h1, 1'b0, 32'h400, 32'h500);
    accept("null");

    // Chained descriptor at 0x80, held for 10 cycles; starts while held are ignored
    load_desc(32'h80, {16'h10, 3'b0}, 32'h1200, 32'h4001, 32'h1400, 32'h1500);
    fetch(32'h80, lat);
    exp_log = '{32'h80, 32'h88, 32'h90, 32'h98};
    check_log("chain");
    for (int i = 0; i < 10; i++) begin
      fetch_start = (i == 3);
      fetch_addr  = 32'h4;
      @(negedge clk);
      check($sformatf("hold%0d_busy", i),  32'(fetch_busy), 32'd1);
      check($sformatf("hold%0d_valid", i), 32'(desc_valid), 32'd1);
      check($sformatf("hold%0d_next", i),  desc_next, 32'h80);
    end
    fetch_start = 1'b0;
    check_desc("chain", 32'h80, 32'h1200, 32'h4001, 1'b1, 32'h1400, 32'h1500);
    // Start coinciding with the handshake is dropped
    fetch_start = 1'b1;
    fetch_addr  = 32'h0;
    accept("chain");
    fetch_start = 1'b0;
    @(negedge clk);
    check("chain_start_ignored_busy", 32'(fetch_busy), 32'd0);

    // Two retries on beat 2
    load_desc(32'h0, 32'h600, 32'h610, 32'h2, 32'h620, 32'h630);
    rty_beat = 2;
    rty_left = 2;
    fetch(32'h0, lat);
    exp_log = '{32'h0, 32'h8, 32'h10, GAP, 32'h10, GAP, 32'h10, 32'h18};
    check_log("rty2");
    check_desc("rty2", 32'h600, 32'h610, 32'h2, 1'b0, 32'h620, 32'h630);
    accept("rty2");

    // RETRY_MAX+1 retries on beat 2 -> error
    rty_left = RETRY_MAX + 1;
    fetch(32'h0, lat);
    check("rtymax_err",   32'(desc_err), 32'd1);
    check("rtymax_valid", 32'(desc_valid), 32'd1);
    check("rtymax_len",   32'(adr_log.size()), 32'd11);
    check("rtymax_left",  32'(rty_left), 32'd0);
    accept("rtymax");
    rty_beat = -1;

    // Bus error on beat 1
    err_beat = 1;
    fetch(32'h0, lat);
    exp_log = '{32'h0, 32'h8};
    check_log("berr");
    check("berr_err", 32'(desc_err), 32'd1);
    check("berr_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
    check("berr_latency", 32'(lat), 32'd4);
    accept("berr");
    err_beat = -1;

    // Misaligned start
    fetch(32'h4, lat);
    check("mis_latency", 32'(lat), 32'd2);
    check("mis_err", 32'(desc_err), 32'd1);
    check("mis_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
    check("mis_len", 32'(adr_log.size()), 32'd0);
    accept("mis");

    // Reset during beat 2 drops the bus asynchronously
    load_desc(32'h0, 32'h700, 32'h710, 32'h16, 32'h720, 32'h730);
    fetch(32'h0, lat);
    accept("pre_rst");
    @(negedge clk);
    fetch_start = 1'b1;
    fetch_addr  = 32'h0;
    @(negedge clk);
    fetch_start = 1'b0;
    waited = 0;
    while (!(wbm_if.wbm_cyc_o && wbm_if.wbm_adr_o == 32'h10) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("mid_reached_beat2", 32'(wbm_if.wbm_adr_o), 32'h10);
    #1 rst = 1'b1;
    #1;
    check("mid_cyc",   32'(wbm_if.wbm_cyc_o), 32'd0);
    check("mid_stb",   32'(wbm_if.wbm_stb_o), 32'd0);
    check("mid_cab",   32'(wbm_if.wbm_cab_o), 32'd0);
    check("mid_adr",   wbm_if.wbm_adr_o, 32'd0);
    check("mid_busy",  32'(fetch_busy), 32'd0);
    check("mid_valid", 32'(desc_valid), 32'd0);
    check("mid_next",  desc_next, 32'd0);
    check("mid_ctl",   desc_ctl,  32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0, lat);
    exp_log = '{32'h0, 32'h8, 32'h10, 32'h18};
    check_log("post_rst");
    check_desc("post_rst", 32'h700, 32'h710, 32'h16, 1'b0, 32'h720, 32'h730);
    accept("post_rst");

    // Slave never terminates
    hang = 1'b1;
`ifdef ADMA_DESC_TIMEOUT_EN
    fetch(32'h0, lat);
    check("to_latency", 32'(lat), 32'(TIMEOUT + 2));
    check("to_err",     32'(desc_err), 32'd1);
    check("to_cyc",     32'(wbm_if.wbm_cyc_o), 32'd0);
    accept("to");
`else
    @(negedge clk);
    fetch_start = 1'b1;
    fetch_addr  = 32'h0;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (40) @(negedge clk);
    check("hang_busy",  32'(fetch_busy), 32'd1);
    check("hang_cyc",   32'(wbm_if.wbm_cyc_o), 32'd1);
    check("hang_valid", 32'(desc_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    hang = 1'b0;

    check("bus_ctl_static", 32'(ctl_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
